// File: rtl/ring_gain_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : ring_gain_scheduler_if
// Run request, divided clock, phase error, and status/gain bus of one ring node.
// Revision: 1.0  initial release
// ============================================================================
interface ring_gain_scheduler_if #(
  parameter int PDET_WIDTH = 5,
  parameter int KP_WIDTH   = 6,
  parameter int KI_WIDTH   = 8
);
  logic                         enable_i;
  logic                         gen_div_i;
  logic signed [PDET_WIDTH-1:0] error_i;
  logic                         ring_reset_o;
  logic                         ring_enable_o;
  logic [KP_WIDTH-1:0]          kp_o;
  logic [KI_WIDTH-1:0]          ki_o;
  logic                         locked_o;
  logic                         fault_o;
  logic [2:0]                   state_o;

  modport master (
    output enable_i, gen_div_i, error_i,
    input  ring_reset_o, ring_enable_o, kp_o, ki_o, locked_o, fault_o, state_o
  );

  modport slave (
    input  enable_i, gen_div_i, error_i,
    output ring_reset_o, ring_enable_o, kp_o, ki_o, locked_o, fault_o, state_o
  );
endinterface
`default_nettype wire

// File: rtl/ring_gain_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : ring_gain_scheduler
// Ring-node startup and acquire/track gain scheduler.
// Optional macro RING_SCHED_TIMEOUT_EN adds ACQUIRE timeout, retries and FAULT.
// Revision: 1.0  initial release
// ============================================================================
module ring_gain_scheduler #(
  parameter int                  PDET_WIDTH   = 5,
  parameter int                  KP_WIDTH     = 6,
  parameter int                  KI_WIDTH     = 8,
  parameter logic [KP_WIDTH-1:0] KP_ACQ       = 6'b010010,
  parameter logic [KI_WIDTH-1:0] KI_ACQ       = 8'b00000100,
  parameter logic [KP_WIDTH-1:0] KP_TRK       = 6'b001001,
  parameter logic [KI_WIDTH-1:0] KI_TRK       = 8'b00000001,
  parameter int                  RST_CYCLES   = 16,
  parameter int                  WARMUP_EDGES = 8,
  parameter int                  LOCK_TOL     = 1,
  parameter int                  LOCK_COUNT   = 32,
  parameter int                  UNLOCK_TOL   = 3,
  parameter int                  UNLOCK_COUNT = 4,
  parameter int                  ACQ_TIMEOUT  = 1024,
  parameter int                  MAX_RETRIES  = 3
) (
  input  logic                 fpga_clk_i,
  input  logic                 reset_i,
  ring_gain_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESET   = 3'd1,
    S_WARMUP  = 3'd2,
    S_ACQUIRE = 3'd3,
    S_TRACK   = 3'd4,
    S_FAULT   = 3'd5
  } state_e;

  localparam int CYC_W  = $clog2(RST_CYCLES + 1);
  localparam int WU_W   = $clog2(WARMUP_EDGES + 1);
  localparam int LOCK_W = $clog2(LOCK_COUNT + 1);
  localparam int UNL_W  = $clog2(UNLOCK_COUNT + 1);
  localparam int MAG_W  = PDET_WIDTH + 1;

  localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0]  CYC_MAX  = CYC_W'(RST_CYCLES);
  localparam logic [WU_W-1:0]   WU_MAX   = WU_W'(WARMUP_EDGES);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_COUNT);
  localparam logic [UNL_W-1:0]  UNL_MAX  = UNL_W'(UNLOCK_COUNT);

  state_e                       state_q, state_d;
  logic [2:0]                   sync_q;
  logic                         sample_q;
  logic signed [PDET_WIDTH-1:0] err_q;
  logic [CYC_W-1:0]             cyc_q, cyc_d;
  logic [WU_W-1:0]              wu_q, wu_d;
  logic [LOCK_W-1:0]            lock_q, lock_d;
  logic [UNL_W-1:0]             unl_q, unl_d;
  logic                         ring_reset_q, ring_enable_q, locked_q;
  logic [KP_WIDTH-1:0]          kp_q;
  logic [KI_WIDTH-1:0]          ki_q;

  logic                         w_edge;
  logic [MAG_W-1:0]             w_err_ext, w_mag;
  logic                         w_in_lock, w_out_lock;

`ifdef RING_SCHED_TIMEOUT_EN
  localparam int ACQ_W = $clog2(ACQ_TIMEOUT + 1);
  localparam int RTY_W = $clog2(MAX_RETRIES + 1);
  localparam logic [ACQ_W-1:0] ACQ_MAX = ACQ_W'(ACQ_TIMEOUT);
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRIES);

  logic [ACQ_W-1:0] acq_q, acq_d;
  logic [RTY_W-1:0] rty_q, rty_d;
  logic             fault_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{ACQ_TIMEOUT[0], MAX_RETRIES[0]};
`endif

  // sync_q[2] is the edge flop: one-cycle pulse on a synchronised rise
  assign w_edge     = sync_q[1] & ~sync_q[2];
  assign w_err_ext  = {err_q[PDET_WIDTH-1], err_q};
  assign w_mag      = w_err_ext[MAG_W-1] ? (~w_err_ext + MAG_W'(1)) : w_err_ext;
  assign w_in_lock  = (w_mag <= MAG_W'(LOCK_TOL));
  assign w_out_lock = (w_mag >  MAG_W'(UNLOCK_TOL));

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    wu_d    = wu_q;
    lock_d  = lock_q;
    unl_d   = unl_q;
`ifdef RING_SCHED_TIMEOUT_EN
    acq_d   = acq_q;
    rty_d   = rty_q;
`endif
    if (!bus.enable_i || (state_q == S_IDLE)) begin
      state_d = bus.enable_i ? S_RESET : S_IDLE;
      cyc_d   = '0;
      wu_d    = '0;
      lock_d  = '0;
      unl_d   = '0;
`ifdef RING_SCHED_TIMEOUT_EN
      acq_d   = '0;
      rty_d   = '0;
`endif
    end else begin
      unique case (state_q)
        S_RESET: begin
          if (cyc_q == CYC_LAST) begin
            state_d = S_WARMUP;
            wu_d    = '0;
          end else begin
            cyc_d = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + 1'b1;
          end
        end
        S_WARMUP: if (sample_q) begin
          wu_d = (wu_q == WU_MAX) ? wu_q : wu_q + 1'b1;
          if (wu_d == WU_MAX) begin
            state_d = S_ACQUIRE;
            lock_d  = '0;
`ifdef RING_SCHED_TIMEOUT_EN
            acq_d   = '0;
`endif
          end
        end
        S_ACQUIRE: if (sample_q) begin
          lock_d = !w_in_lock ? '0 : ((lock_q == LOCK_MAX) ? lock_q : lock_q + 1'b1);
          if (lock_d == LOCK_MAX) begin
            state_d = S_TRACK;
            unl_d   = '0;
`ifdef RING_SCHED_TIMEOUT_EN
            rty_d   = '0;
            acq_d   = '0;
`endif
          end
`ifdef RING_SCHED_TIMEOUT_EN
          else begin
            acq_d = (acq_q == ACQ_MAX) ? acq_q : acq_q + 1'b1;
            if (acq_d == ACQ_MAX) begin
              acq_d = '0;
              if (rty_q == RTY_MAX) begin
                state_d = S_FAULT;
              end else begin
                // retry count deliberately survives the restart
                rty_d   = rty_q + 1'b1;
                cyc_d   = '0;
                wu_d    = '0;
                state_d = S_RESET;
              end
            end
          end
`endif
        end
        S_TRACK: if (sample_q) begin
          unl_d = !w_out_lock ? '0 : ((unl_q == UNL_MAX) ? unl_q : unl_q + 1'b1);
          if (unl_d == UNL_MAX) begin
            state_d = S_ACQUIRE;
            lock_d  = '0;
            unl_d   = '0;
`ifdef RING_SCHED_TIMEOUT_EN
            acq_d   = '0;
`endif
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge fpga_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q       <= S_IDLE;
      sync_q        <= '0;
      sample_q      <= 1'b0;
      err_q         <= '0;
      cyc_q         <= '0;
      wu_q          <= '0;
      lock_q        <= '0;
      unl_q         <= '0;
      ring_reset_q  <= 1'b1;
      ring_enable_q <= 1'b0;
      locked_q      <= 1'b0;
      kp_q          <= KP_ACQ;
      ki_q          <= KI_ACQ;
`ifdef RING_SCHED_TIMEOUT_EN
      acq_q         <= '0;
      rty_q         <= '0;
      fault_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      sync_q        <= {sync_q[1:0], bus.gen_div_i};
      // an enable drop in the edge cycle discards that sample
      sample_q      <= w_edge & bus.enable_i;
      if (w_edge) err_q <= bus.error_i;
      cyc_q         <= cyc_d;
      wu_q          <= wu_d;
      lock_q        <= lock_d;
      unl_q         <= unl_d;
      ring_reset_q  <= (state_d == S_IDLE) || (state_d == S_RESET) || (state_d == S_FAULT);
      ring_enable_q <= !((state_d == S_IDLE) || (state_d == S_FAULT));
      locked_q      <= (state_d == S_TRACK);
      kp_q          <= (state_d == S_TRACK) ? KP_TRK : KP_ACQ;
      ki_q          <= (state_d == S_TRACK) ? KI_TRK : KI_ACQ;
`ifdef RING_SCHED_TIMEOUT_EN
      acq_q         <= acq_d;
      rty_q         <= rty_d;
      fault_q       <= (state_d == S_FAULT);
`endif
    end
  end

  assign bus.state_o       = state_q;
  assign bus.ring_reset_o  = ring_reset_q;
  assign bus.ring_enable_o = ring_enable_q;
  assign bus.locked_o      = locked_q;
  assign bus.kp_o          = kp_q;
  assign bus.ki_o          = ki_q;
`ifdef RING_SCHED_TIMEOUT_EN
  assign bus.fault_o       = fault_q;
`else
  assign bus.fault_o       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ring_gain_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_ring_gain_scheduler
// Directed plus randomised bench for ring_gain_scheduler with a sample-level model.
// Revision: 1.0  initial release
// ============================================================================
module tb_ring_gain_scheduler;

  localparam int RST_CYCLES   = 16;
  localparam int WARMUP_EDGES = 8;
  localparam int LOCK_TOL     = 1;
  localparam int LOCK_COUNT   = 32;
  localparam int UNLOCK_TOL   = 3;
  localparam int UNLOCK_COUNT = 4;
  localparam int ACQ_TIMEOUT  = 1024;
  localparam int MAX_RETRIES  = 3;
  localparam logic [5:0] KP_ACQ = 6'b010010;
  localparam logic [7:0] KI_ACQ = 8'b00000100;
  localparam logic [5:0] KP_TRK = 6'b001001;
  localparam logic [7:0] KI_TRK = 8'b00000001;

  localparam int M_IDLE = 0, M_RESET = 1, M_WARMUP = 2, M_ACQ = 3, M_TRACK = 4, M_FAULT = 5;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  ring_gain_scheduler_if #(.PDET_WIDTH(5), .KP_WIDTH(6), .KI_WIDTH(8)) bus ();

  ring_gain_scheduler dut (
    .fpga_clk_i (clk),
    .reset_i    (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: one update per accepted divided-clock sample
  int m_state, m_wu, m_lock, m_unlock, m_acq, m_retry;

  function automatic void model_idle();
    m_state = M_IDLE; m_wu = 0; m_lock = 0; m_unlock = 0; m_acq = 0; m_retry = 0;
  endfunction

  function automatic void model_sample(input int err);
    int mag;
    mag = (err < 0) ? -err : err;
    case (m_state)
      M_WARMUP: begin
        m_wu++;
        if (m_wu >= WARMUP_EDGES) begin m_state = M_ACQ; m_lock = 0; m_acq = 0; end
      end
      M_ACQ: begin
        m_lock = (mag <= LOCK_TOL) ? m_lock + 1 : 0;
        m_acq++;
        if (m_lock >= LOCK_COUNT) begin
          m_state = M_TRACK; m_unlock = 0; m_retry = 0;
        end
`ifdef RING_SCHED_TIMEOUT_EN
        else if (m_acq >= ACQ_TIMEOUT) begin
          m_acq = 0;
          if (m_retry == MAX_RETRIES) m_state = M_FAULT;
          else begin m_retry++; m_state = M_RESET; end
        end
`endif
      end
      M_TRACK: begin
        m_unlock = (mag > UNLOCK_TOL) ? m_unlock + 1 : 0;
        if (m_unlock >= UNLOCK_COUNT) begin m_state = M_ACQ; m_lock = 0; m_unlock = 0; m_acq = 0; end
      end
      default: ;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic trk, flt;
    trk = (m_state == M_TRACK);
    flt = (m_state == M_FAULT);
    chk({tag, ".state"},  32'(bus.state_o), 32'(m_state));
    chk({tag, ".rreset"}, 32'(bus.ring_reset_o),
        32'(m_state == M_IDLE || m_state == M_RESET || flt));
    chk({tag, ".renable"}, 32'(bus.ring_enable_o), 32'(!(m_state == M_IDLE || flt)));
    chk({tag, ".locked"}, 32'(bus.locked_o), 32'(trk));
    chk({tag, ".fault"},  32'(bus.fault_o), 32'(flt));
    chk({tag, ".kp"},     32'(bus.kp_o), 32'(trk ? KP_TRK : KP_ACQ));
    chk({tag, ".ki"},     32'(bus.ki_o), 32'(trk ? KI_TRK : KI_ACQ));
  endtask

  // one divided-clock rise; outputs must not move on the 3rd cycle and must on the 4th
  task automatic div_edge(input int err);
    bus.error_i   = 5'(err);
    bus.gen_div_i = 1'b1;
    repeat (3) @(negedge clk);
    check_all("edge_pre");
    @(negedge clk);
    model_sample(err);
    check_all("edge_post");
    if (m_state == M_RESET) begin
      repeat (RST_CYCLES) @(negedge clk);
      m_state = M_WARMUP; m_wu = 0;
      check_all("restart");
    end
    bus.gen_div_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic start_ring();
    bus.enable_i = 1'b1;
    m_state = M_RESET;
    for (int i = 1; i <= RST_CYCLES + 1; i++) begin
      @(negedge clk);
      if (i > RST_CYCLES) begin m_state = M_WARMUP; m_wu = 0; end
      check_all((i > RST_CYCLES) ? "reset_exit" : "reset_hold");
    end
  endtask

  task automatic reach_track();
    if (m_state == M_IDLE) begin
      start_ring();
      repeat (WARMUP_EDGES) div_edge(int'($urandom_range(0, 31)) - 16);
    end
    for (int n = 0; n < 2 * LOCK_COUNT && m_state != M_TRACK; n++) div_edge(0);
    chk("reach_track", 32'(bus.locked_o), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len, mode, e;
    rst_n         = 1'b0;
    bus.enable_i  = 1'b0;
    bus.gen_div_i = 1'b0;
    bus.error_i   = '0;
    model_idle();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all("idle");

    start_ring();
    repeat (WARMUP_EDGES) div_edge(int'($urandom_range(0, 31)) - 16);
    chk("acq_entry", 32'(bus.state_o), 32'(M_ACQ));

    repeat (LOCK_COUNT) div_edge(0);
    chk("lock_kp", 32'(bus.kp_o), 32'(6'b001001));
    chk("lock_flag", 32'(bus.locked_o), 32'd1);

    repeat (10) div_edge(2);
    chk("hyst_locked", 32'(bus.locked_o), 32'd1);
    div_edge(5); div_edge(5); div_edge(5); div_edge(-16);
    chk("unlock_state", 32'(bus.state_o), 32'(M_ACQ));

    repeat (LOCK_COUNT - 1) div_edge(0);
    div_edge(3);
    repeat (LOCK_COUNT - 1) div_edge(0);
    chk("relock_pending", 32'(bus.state_o), 32'(M_ACQ));
    div_edge(0);
    chk("relock_done", 32'(bus.state_o), 32'(M_TRACK));

    for (int b = 0; b < 12; b++) begin
      len  = int'($urandom_range(1, 40));
      mode = int'($urandom_range(0, 2));
      for (int k = 0; k < len; k++) begin
        case (mode)
          0:       e = int'($urandom_range(0, 2)) - 1;
          1:       e = int'($urandom_range(0, 6)) - 3;
          default: e = int'($urandom_range(0, 31)) - 16;
        endcase
        div_edge(e);
      end
    end

    while (m_state == M_TRACK) div_edge(10);
`ifdef RING_SCHED_TIMEOUT_EN
    for (int n = 0; n < 6000 && m_state != M_FAULT; n++) div_edge(10);
    chk("fault_flag", 32'(bus.fault_o), 32'd1);
    chk("fault_ring_en", 32'(bus.ring_enable_o), 32'd0);
    repeat (3) @(negedge clk);
    check_all("fault_hold");
    bus.enable_i = 1'b0;
    @(negedge clk);
    model_idle();
    check_all("fault_exit");
`else
    repeat (40) div_edge(10);
    chk("no_timeout", 32'(bus.state_o), 32'(M_ACQ));
`endif

    reach_track();
    bus.error_i   = 5'(10);
    bus.gen_div_i = 1'b1;
    repeat (2) @(negedge clk);
    bus.enable_i = 1'b0;
    @(negedge clk);
    model_idle();
    check_all("drop_en");
    bus.gen_div_i = 1'b0;
    repeat (4) @(negedge clk);
    check_all("drop_en_hold");

    start_ring();
    repeat (3) div_edge(0);
    #2 rst_n = 1'b0;
    #1 model_idle();
    check_all("async_rst");
    @(negedge clk);
    check_all("async_rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    m_state = M_RESET;
    check_all("post_rst_restart");
    bus.enable_i = 1'b0;
    @(negedge clk);
    model_idle();
    check_all("final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ring_gain_scheduler.md
# ring_gain_scheduler

Startup and gain-scheduling controller for one oscillator node of the ADPLL network ring. It runs in the `fpga_clk_i` domain and holds the node's ring in reset, then releases it and waits for the divided generated clock to settle. After that it drives wide acquisition loop-filter gains until the combined phase error stays small, then switches to narrow tracking gains. It monitors for loss of lock and reports state and lock status to the top level.

## Interface
- `PDET_WIDTH`, 5: width of the combined signed phase error.
- `KP_WIDTH`, 6: width of the proportional-gain output.
- `KI_WIDTH`, 8: width of the integral-gain output.
- `KP_ACQ`, 6'b010010: kp driven in ACQUIRE.
- `KI_ACQ`, 8'b00000100: ki driven in ACQUIRE.
- `KP_TRK`, 6'b001001: kp driven in TRACK.
- `KI_TRK`, 8'b00000001: ki driven in TRACK.
- `RST_CYCLES`, 16: `fpga_clk_i` cycles for which the ring reset is held.
- `WARMUP_EDGES`, 8: divided-clock edges ignored after the ring is released.
- `LOCK_TOL`, 1: |error| at or below this value counts as in-lock.
- `LOCK_COUNT`, 32: consecutive in-lock edges needed to enter TRACK.
- `UNLOCK_TOL`, 3: |error| above this value counts as out-of-lock.
- `UNLOCK_COUNT`, 4: consecutive out-of-lock edges that force a return to ACQUIRE.
- `ACQ_TIMEOUT`, 1024: maximum ACQUIRE edges per attempt (timeout feature only).
- `MAX_RETRIES`, 3: number of restarts before FAULT (timeout feature only).

Ports:
- `fpga_clk_i`, input, 1: system clock.
- `reset_i`, input, 1: asynchronous, active-low reset.
- `enable_i`, input, 1: run request, level-sensitive.
- `gen_div_i`, input, 1: divided generated clock, asynchronous to `fpga_clk_i`.
- `error_i`, input, PDET_WIDTH: signed combined phase error. It is stable around `gen_div_i` rising edges.
- `ring_reset_o`, output, 1: active-high reset to the ring node.
- `ring_enable_o`, output, 1: ring oscillator enable.
- `kp_o`, output, KP_WIDTH: loop-filter kp.
- `ki_o`, output, KI_WIDTH: loop-filter ki.
- `locked_o`, output, 1: high while in TRACK.
- `fault_o`, output, 1: high while in FAULT.
- `state_o`, output, 3: current state encoding.

## Operation
- `gen_div_i` passes through a 2-flop synchroniser and a third edge flop. A rising edge produces a one-cycle `edge` pulse.
- `error_i` is captured in the same cycle that `edge` is high.
- Magnitude is computed in PDET_WIDTH+1 bits, so the most negative value gives 2^(PDET_WIDTH-1) and does not overflow.
- States and encodings: IDLE=0, RESET=1, WARMUP=2, ACQUIRE=3, TRACK=4, FAULT=5.
- **IDLE.** `ring_reset_o`=1 and `ring_enable_o`=0. Goes to RESET when `enable_i`=1.
- **RESET.** `ring_reset_o`=1 and `ring_enable_o`=1. The cycle counter counts RST_CYCLES, then the block goes to WARMUP.
- **WARMUP.** `ring_reset_o`=0. After WARMUP_EDGES edges the block goes to ACQUIRE and clears the lock counter.
- **ACQUIRE.** `kp_o`/`ki_o` = ACQ values. On each edge:
  - if |err| ≤ LOCK_TOL, the lock counter increments;
  - otherwise the lock counter clears.
  - When the counter reaches LOCK_COUNT, go to TRACK.
- **TRACK.** `kp_o`/`ki_o` = TRK values and `locked_o`=1. On each edge:
  - if |err| > UNLOCK_TOL, the unlock counter increments;
  - otherwise the unlock counter clears.
  - When it reaches UNLOCK_COUNT, go to ACQUIRE with the lock counter cleared.
- Between LOCK_TOL and UNLOCK_TOL is hysteresis: such a sample in TRACK clears the unlock counter.
- **FAULT.** `ring_reset_o`=1 and `ring_enable_o`=0. The block stays in FAULT until `enable_i`=0, then goes to IDLE.
- In any state, `enable_i`=0 returns the block to IDLE on the next cycle. All counters clear.
- Counters saturate and never wrap.
- Gain outputs are ACQ values in every state except TRACK.

## Timing
- Reset values: state IDLE, `ring_reset_o`=1, `ring_enable_o`=0, `kp_o`=KP_ACQ, `ki_o`=KI_ACQ, `locked_o`=0, `fault_o`=0, all counters 0.
- All outputs are registered and are decoded from the next state, so they change in the same cycle as the state.
- Latency from a `gen_div_i` rise to `edge`: 3 cycles.
- The qualifying sample moves the state on the following clock.
- An edge and a drop of `enable_i` in the same cycle: the drop wins, and the edge is ignored.
- Asserting `reset_i` mid-operation returns the block immediately, and asynchronously, to the reset values.

## Configuration
- `RING_SCHED_TIMEOUT_EN` defined:
  - an ACQUIRE edge counter and a retry counter are compiled in;
  - reaching ACQ_TIMEOUT edges in ACQUIRE increments retries and goes to RESET;
  - the retry count is kept across this restart;
  - a timeout when retries = MAX_RETRIES goes to FAULT instead;
  - retries clear on entering TRACK and in IDLE.
- Not defined: ACQUIRE waits indefinitely, FAULT is unreachable, and `fault_o` is tied to 0.

## Test plan
- Reset, then `enable_i`=1: RESET held exactly 16 cycles → WARMUP; `ring_reset_o` falls on the 17th cycle after entering RESET.
- After 8 warmup edges, drive error=0 for 32 edges → `locked_o`=1 and `kp_o`=6'b001001, 4 cycles after the 32nd `gen_div_i` rise.
- In TRACK: error=2 for 10 edges → stays locked. Then +5, +5, +5, −16 on consecutive edges → ACQUIRE on the 4th; the −16 sample also checks magnitude handling.
- In ACQUIRE: 31 samples of 0, then 1 sample of 3, then 31 samples of 0 → still ACQUIRE; one more 0 → TRACK.
- With the macro defined and constant error=10: ACQUIRE times out at 1024 edges; after 3 retries, the fourth timeout → `fault_o`=1 and `ring_enable_o`=0. Then `enable_i`=0 → IDLE.
- Drop `enable_i` on the same cycle as an edge in TRACK, and pulse `reset_i` mid-WARMUP → IDLE and the reset values in both cases.
